// File: rtl/acq_sequencer.sv
// Acquisition frame sequencer for the scope front end (sys_clk domain).
//
// Each frame starts with a one-cycle sync strobe, waits a programmable delay,
// then opens a window of len ADC samples with a clock-enable every ADC_DIV
// cycles. The next frame starts max(period, frame length) cycles after the
// sync. Frame configuration is double-buffered: loads go to pending registers
// and are applied only at frame boundaries (and continuously while idle).
//
// Ports:
//   sys_clk, rst           clock, asynchronous active-high reset
//   i_start / i_stop       arm (idle only) / stop after the current frame
//   i_cfg_ld               capture i_period/i_delay/i_len into pending regs
//   o_sync                 one-cycle frame-start pulse
//   o_acq_en, o_adc_ce     acquisition window level, per-sample enable
//   o_sample_idx           sample index within the frame, 0 outside window
//   o_frame_done           one-cycle frame-complete pulse
//   o_frame_cnt            completed frame count (wraps)
//   o_busy, o_overrun      not idle, sticky period-shorter-than-frame flag
module acq_sequencer #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ADC_DIV    = 5,
  parameter int unsigned DEF_PERIOD = 1000,
  parameter int unsigned DEF_DELAY  = 0,
  parameter int unsigned DEF_LEN    = 64
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_cfg_ld,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_delay,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_sync,
  output logic             o_acq_en,
  output logic             o_adc_ce,
  output logic [CNT_W-1:0] o_sample_idx,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic             o_busy,
  output logic             o_overrun
);

  // Wide enough for 1 + delay + len*ADC_DIV without truncation.
  localparam int unsigned FW    = CNT_W + $clog2(ADC_DIV + 1) + 1;
  localparam int unsigned DIV_W = (ADC_DIV > 1) ? $clog2(ADC_DIV) : 1;
  localparam logic [DIV_W-1:0] DivMax = DIV_W'(ADC_DIV - 1);

  typedef enum logic [2:0] {StIdle, StSync, StDelay, StAcq, StWait} state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    pcnt_q, pcnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] act_period_q, act_period_d, act_delay_q, act_delay_d;
  logic [CNT_W-1:0] act_len_q, act_len_d;
  logic [CNT_W-1:0] pend_period_q, pend_period_d, pend_delay_q, pend_delay_d;
  logic [CNT_W-1:0] pend_len_q, pend_len_d;
  logic             stop_q, stop_d;
  logic             sync_q, sync_d, acq_q, acq_d, ce_q, ce_d;
  logic             done_q, done_d, busy_q, busy_d, ovr_q, ovr_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  logic [FW-1:0]    frame_len;
  logic [FW-1:0]    sync_pt;
  logic [FW-1:0]    pcnt_n;

  always_comb begin
    frame_len = FW'(1) + FW'(act_delay_q) + FW'(act_len_q) * FW'(ADC_DIV);
    sync_pt   = (FW'(act_period_q) > frame_len) ? FW'(act_period_q) : frame_len;
    pcnt_n    = pcnt_q + FW'(1);

    state_d       = state_q;
    pcnt_d        = pcnt_q;
    act_period_d  = act_period_q;
    act_delay_d   = act_delay_q;
    act_len_d     = act_len_q;
    pend_period_d = pend_period_q;
    pend_delay_d  = pend_delay_q;
    pend_len_d    = pend_len_q;
    stop_d        = stop_q;
    done_d        = 1'b0;
    fcnt_d        = fcnt_q;
    ovr_d         = ovr_q;

    if (i_cfg_ld) begin
      pend_period_d = i_period;
      pend_delay_d  = i_delay;
      pend_len_d    = i_len;
    end

    if (state_q == StIdle) begin
      act_period_d = pend_period_q;
      act_delay_d  = pend_delay_q;
      act_len_d    = pend_len_q;
      // Simultaneous stop overrides start.
      if (i_start && !i_stop) begin
        state_d = StSync;
        pcnt_d  = '0;
        ovr_d   = 1'b0;
        stop_d  = 1'b0;
      end
    end else begin
      if (i_stop) stop_d = 1'b1;
      if (pcnt_n == frame_len) begin
        done_d = 1'b1;
        fcnt_d = fcnt_q + CNT_W'(1);
      end
      if (pcnt_n >= sync_pt) begin
        if (FW'(act_period_q) < frame_len) ovr_d = 1'b1;
        pcnt_d = '0;
        if (stop_q || i_stop) begin
          state_d = StIdle;
          stop_d  = 1'b0;
        end else begin
          state_d      = StSync;
          act_period_d = pend_period_q;
          act_delay_d  = pend_delay_q;
          act_len_d    = pend_len_q;
        end
      end else begin
        pcnt_d = pcnt_n;
        if (pcnt_n <= FW'(act_delay_q)) begin
          state_d = StDelay;
        end else if (pcnt_n < frame_len) begin
          state_d = StAcq;
        end else begin
          state_d = StWait;
        end
      end
    end

    // Sample enable divider restarts on every window entry so the first
    // enable lands on the first window cycle.
    div_d = '0;
    idx_d = '0;
    ce_d  = 1'b0;
    if (state_d == StAcq) begin
      if (state_q != StAcq) begin
        ce_d = 1'b1;
      end else if (div_q == DivMax) begin
        idx_d = idx_q + CNT_W'(1);
        ce_d  = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
      end
    end

    sync_d = (state_d == StSync);
    acq_d  = (state_d == StAcq);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pcnt_q        <= '0;
      div_q         <= '0;
      idx_q         <= '0;
      act_period_q  <= CNT_W'(DEF_PERIOD);
      act_delay_q   <= CNT_W'(DEF_DELAY);
      act_len_q     <= CNT_W'(DEF_LEN);
      pend_period_q <= CNT_W'(DEF_PERIOD);
      pend_delay_q  <= CNT_W'(DEF_DELAY);
      pend_len_q    <= CNT_W'(DEF_LEN);
      stop_q        <= 1'b0;
      sync_q        <= 1'b0;
      acq_q         <= 1'b0;
      ce_q          <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      ovr_q         <= 1'b0;
      fcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      div_q         <= div_d;
      idx_q         <= idx_d;
      act_period_q  <= act_period_d;
      act_delay_q   <= act_delay_d;
      act_len_q     <= act_len_d;
      pend_period_q <= pend_period_d;
      pend_delay_q  <= pend_delay_d;
      pend_len_q    <= pend_len_d;
      stop_q        <= stop_d;
      sync_q        <= sync_d;
      acq_q         <= acq_d;
      ce_q          <= ce_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      ovr_q         <= ovr_d;
      fcnt_q        <= fcnt_d;
    end
  end

  assign o_sync       = sync_q;
  assign o_acq_en     = acq_q;
  assign o_adc_ce     = ce_q;
  assign o_sample_idx = idx_q;
  assign o_frame_done = done_q;
  assign o_frame_cnt  = fcnt_q;
  assign o_busy       = busy_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer (default parameters, ADC_DIV=5).
// Inputs change and outputs are sampled on the falling edge; "p" is the
// number of cycles since the sync cycle of the first frame after i_start.
module tb_acq_sequencer;

  localparam int unsigned CNT_W = 16;

  logic             sys_clk;
  logic             rst;
  logic             i_start, i_stop, i_cfg_ld;
  logic [CNT_W-1:0] i_period, i_delay, i_len;
  logic             o_sync, o_acq_en, o_adc_ce, o_frame_done, o_busy, o_overrun;
  logic [CNT_W-1:0] o_sample_idx, o_frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_fcnt = 0;

  acq_sequencer #(
    .CNT_W     (CNT_W),
    .ADC_DIV   (5),
    .DEF_PERIOD(1000),
    .DEF_DELAY (0),
    .DEF_LEN   (64)
  ) u_dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_cfg_ld    (i_cfg_ld),
    .i_period    (i_period),
    .i_delay     (i_delay),
    .i_len       (i_len),
    .o_sync      (o_sync),
    .o_acq_en    (o_acq_en),
    .o_adc_ce    (o_adc_ce),
    .o_sample_idx(o_sample_idx),
    .o_frame_done(o_frame_done),
    .o_frame_cnt (o_frame_cnt),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input int p, input bit e_sync, input bit e_ce, input bit e_acq,
                             input bit e_done, input bit e_busy, input bit e_ovr);
    if (e_done) exp_fcnt++;
    check_eq($sformatf("sync@%0d", p), o_sync, e_sync);
    check_eq($sformatf("adc_ce@%0d", p), o_adc_ce, e_ce);
    check_eq($sformatf("acq_en@%0d", p), o_acq_en, e_acq);
    check_eq($sformatf("frame_done@%0d", p), o_frame_done, e_done);
    check_eq($sformatf("busy@%0d", p), o_busy, e_busy);
    check_eq($sformatf("overrun@%0d", p), o_overrun, e_ovr);
    check_eq($sformatf("frame_cnt@%0d", p), o_frame_cnt, exp_fcnt);
  endtask

  task automatic load_cfg(input int per, input int del, input int len);
    i_period = CNT_W'(per);
    i_delay  = CNT_W'(del);
    i_len    = CNT_W'(len);
    i_cfg_ld = 1'b1;
    @(negedge sys_clk);
    i_cfg_ld = 1'b0;
    @(negedge sys_clk);
  endtask

  // Leaves the bench at the sample point of the first sync cycle (p=0).
  task automatic start_pulse();
    i_start = 1'b1;
    @(negedge sys_clk);
    i_start = 1'b0;
  endtask

  initial begin
    int q;
    bit run;
    rst      = 1'b1;
    i_start  = 1'b0;
    i_stop   = 1'b0;
    i_cfg_ld = 1'b0;
    i_period = '0;
    i_delay  = '0;
    i_len    = '0;
    repeat (2) @(negedge sys_clk);
    check_cycle(-1, 0, 0, 0, 0, 0, 0);
    check_eq("reset_idx", o_sample_idx, 0);
    rst = 1'b0;
    @(negedge sys_clk);

    // Period 40, delay 3, len 4; stop requested mid-window of the fourth frame.
    load_cfg(40, 3, 4);
    start_pulse();
    for (int p = 0; p <= 165; p++) begin
      q   = p % 40;
      run = (p < 160);
      check_cycle(p, run && q == 0, run && q >= 4 && q <= 19 && (q - 4) % 5 == 0,
                  run && q >= 4 && q <= 23, run && q == 24, run, 0);
      check_eq($sformatf("sample_idx@%0d", p), o_sample_idx,
               (run && q >= 4 && q <= 23) ? (q - 4) / 5 : 0);
      i_stop = (p == 125);
      @(negedge sys_clk);
    end
    i_stop = 1'b0;

    // Start and stop together while idle: stop wins.
    i_start = 1'b1;
    i_stop  = 1'b1;
    @(negedge sys_clk);
    i_start = 1'b0;
    i_stop  = 1'b0;
    for (int p = 0; p < 3; p++) begin
      check_cycle(p, 0, 0, 0, 0, 0, 0);
      @(negedge sys_clk);
    end

    // Period 10 shorter than F=21: frames back to back, overrun sticks.
    load_cfg(10, 0, 4);
    start_pulse();
    for (int p = 0; p <= 66; p++) begin
      q   = p % 21;
      run = (p < 63);
      check_cycle(p, run && q == 0, run && q >= 1 && q <= 16 && (q - 1) % 5 == 0,
                  run && q >= 1 && q <= 20, p > 0 && q == 0 && p <= 63, run, p >= 21);
      i_stop = (p == 50);
      @(negedge sys_clk);
    end
    i_stop = 1'b0;
    start_pulse();
    for (int p = 0; p <= 24; p++) begin
      run = (p < 21);
      check_cycle(p, p == 0, run && p >= 1 && p <= 16 && (p - 1) % 5 == 0,
                  run && p >= 1, p == 21, run, p >= 21);
      i_stop = (p == 0);
      @(negedge sys_clk);
    end
    i_stop = 1'b0;

    // Zero-length window: no samples, frame done right after the delay.
    load_cfg(8, 2, 0);
    start_pulse();
    for (int p = 0; p <= 19; p++) begin
      q   = p % 8;
      run = (p < 16);
      check_cycle(p, run && q == 0, 0, 0, run && q == 3, run, 0);
      i_stop = (p == 10);
      @(negedge sys_clk);
    end
    i_stop = 1'b0;

    // Period equal to F=6: done coincides with the next sync, no overrun.
    load_cfg(6, 0, 1);
    start_pulse();
    for (int p = 0; p <= 14; p++) begin
      q   = p % 6;
      run = (p < 12);
      check_cycle(p, run && q == 0, run && q == 1, run && q >= 1,
                  p > 0 && q == 0 && p <= 12, run, 0);
      i_stop = (p == 7);
      @(negedge sys_clk);
    end
    i_stop = 1'b0;

    // Mid-window reconfiguration applies only from the next frame.
    load_cfg(40, 3, 4);
    i_period = 16'd30;
    i_len    = 16'd2;
    start_pulse();
    for (int p = 0; p <= 103; p++) begin
      int len;
      len = (p < 40) ? 4 : 2;
      q   = (p < 40) ? p : (p - 40) % 30;
      run = (p < 100);
      check_cycle(p, run && q == 0, run && q >= 4 && q < 4 + len * 5 && (q - 4) % 5 == 0,
                  run && q >= 4 && q < 4 + len * 5, run && q == 4 + len * 5, run, 0);
      i_cfg_ld = (p == 10);
      i_stop   = (p == 75);
      @(negedge sys_clk);
    end
    i_stop = 1'b0;

    // Asynchronous reset in the middle of the window.
    start_pulse();
    for (int p = 0; p <= 5; p++) begin
      check_cycle(p, p == 0, p == 4, p >= 4, 0, 1, 0);
      if (p < 5) @(negedge sys_clk);
    end
    rst = 1'b1;
    #1;
    exp_fcnt = 0;
    check_cycle(-2, 0, 0, 0, 0, 0, 0);
    @(negedge sys_clk);
    rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      @(negedge sys_clk);
      check_cycle(-3, 0, 0, 0, 0, 0, 0);
    end

    // Defaults after reset: period 1000, delay 0, len 64 (F=321).
    @(negedge sys_clk);
    start_pulse();
    for (int p = 0; p <= 1002; p++) begin
      run = (p < 1000);
      check_cycle(p, p == 0, p >= 1 && p <= 316 && (p - 1) % 5 == 0,
                  p >= 1 && p <= 320, p == 321, run, 0);
      i_stop = (p == 500);
      @(negedge sys_clk);
    end
    i_stop = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Sequences the acquisition frame for the scope front end, in the sys_clk domain.
- Generates the periodic sync strobe that feeds the clock-sync block.
- After a programmable delay, opens an acquisition window of N ADC samples, with an ADC clock-enable every ADC_DIV sys_clk cycles (default 100 MHz / 20 MHz).
- Holds double-buffered frame configuration, applied only at frame boundaries, and reports frame completion and overrun.

Parameters:
CNT_W, 16, width of period/delay/length/counter fields
ADC_DIV, 5, sys_clk cycles per ADC sample enable (>=1)
DEF_PERIOD, 1000, reset value of period register
DEF_DELAY, 0, reset value of delay register
DEF_LEN, 64, reset value of length register

Ports:
sys_clk  in  1  single clock, all logic rising edge
rst  in  1  asynchronous, active-high reset
i_start  in  1  arm sequencer (honoured in IDLE only)
i_stop  in  1  request stop after current frame
i_cfg_ld  in  1  strobe: capture i_period/i_delay/i_len into pending regs
i_period  in  CNT_W  sync-to-sync spacing, sys_clk cycles
i_delay  in  CNT_W  sync-to-window delay, sys_clk cycles
i_len  in  CNT_W  samples per frame
o_sync  out  1  one-cycle sync pulse, frame start
o_acq_en  out  1  acquisition window level
o_adc_ce  out  1  one-cycle sample enable
o_sample_idx  out  CNT_W  index of current sample within frame
o_frame_done  out  1  one-cycle frame-complete pulse
o_frame_cnt  out  CNT_W  completed frames, wraps
o_busy  out  1  not IDLE
o_overrun  out  1  sticky: period shorter than frame

Behaviour:
- Reset (async, immediate):
  - all outputs 0; state IDLE.
  - active and pending config = DEF_*; stop_pending = 0.
- States: IDLE, SYNC, DELAY, ACQ, WAIT.
- Frame timing:
  - pcnt = sys_clk cycles since SYNC; SYNC cycle is pcnt=0.
  - F = 1 + delay + len*ADC_DIV, computed at CNT_W+log2 width, no truncation.
  - SYNC: one cycle, o_sync=1.
  - DELAY: pcnt 1..delay; skipped if delay=0.
  - ACQ: pcnt delay+1..F-1; o_acq_en=1; skipped if len=0.
  - o_adc_ce=1 at pcnt = delay+1+k*ADC_DIV for k = 0..len-1.
  - o_sample_idx = k, held from its ce until the next ce; 0 outside ACQ.
  - o_frame_done=1 at pcnt=F, one cycle; o_frame_cnt increments at the same edge.
  - WAIT: pcnt F..period-1.
  - Next SYNC at pcnt = max(period, F).
  - If period < F: next SYNC at F, o_overrun set.
  - If period == F: frame_done coincides with the next o_sync; no overrun.
- Config:
  - i_cfg_ld in any state loads pending regs; the last strobe before the boundary wins.
  - Active regs copy pending on entry to SYNC and continuously in IDLE.
  - A frame never sees a mid-frame config change.
- Start/stop:
  - i_start in IDLE → SYNC next cycle.
  - i_start also clears o_overrun and stop_pending.
  - i_start while busy is ignored.
  - i_stop in any busy state sets stop_pending; the current frame completes in full, including WAIT.
  - At the next-SYNC point with stop_pending set: go to IDLE instead of SYNC, clear stop_pending, emit no o_sync.
  - i_stop in IDLE: no effect.
  - i_start and i_stop in the same IDLE cycle: stop wins, remain IDLE.
- Period of 0 or 1 is treated as period < F: back-to-back frames, overrun set.
- o_frame_cnt wraps from 2^CNT_W-1 to 0.

Test Plan:
1. ADC_DIV=5, delay=3, len=4, period=40, pulse i_start → o_sync at pcnt 0 and every 40 cycles; o_adc_ce at pcnt 4,9,14,19; o_acq_en high pcnt 4..23; o_frame_done at pcnt 24; o_frame_cnt 1,2,3 after successive frames.
2. delay=0, len=4, period=10 → F=21; o_sync every 21 cycles; o_overrun=1 after first frame; i_start from IDLE clears it.
3. delay=2, len=0, period=8 → no o_adc_ce, o_acq_en stays 0; o_frame_done at pcnt 3; o_sync every 8 cycles.
4. Running with period=40, len=4; i_cfg_ld with len=2, period=30 during ACQ → current frame keeps 4 samples and 40-cycle spacing; next frame has 2 ce pulses; spacing thereafter 30.
5. i_stop during ACQ of a period=40 frame → frame finishes, o_frame_done pulses, o_busy drops at pcnt 40, no further o_sync; i_start+i_stop in the same IDLE cycle → stays IDLE.
6. Assert rst mid-ACQ → o_acq_en, o_adc_ce, o_busy, o_frame_cnt = 0 before the next sys_clk edge; after release, config = DEF_* and the block is idle until i_start.
